// File: rtl/imm_ext_pkg.sv
// Shared immediate-format encodings and the imm_src legality check.
// IMM_EXT_ZICSR_UIMM_EN makes imm_src 101 (CSR zimm) legal; otherwise it is illegal.
package imm_ext_pkg;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100,
      IMM_Z = 3'b101
   } imm_src_e;

   function automatic logic imm_src_legal(input logic [2:0] src);
      logic v_legal;
      v_legal = (src <= 3'(IMM_J));
`ifdef IMM_EXT_ZICSR_UIMM_EN
      if (src == 3'(IMM_Z)) v_legal = 1'b1;
`else
      if (src == 3'(IMM_Z)) v_legal = 1'b0;
`endif
      return v_legal;
   endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational RV immediate decoder: picks the format, sign-extends to XLEN,
// and forces zero with an illegal flag for unsupported imm_src values.
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instruction,
   input  logic [2:0]      i_imm_src,
   output logic [XLEN-1:0] o_imm_ext,
   output logic            o_illegal
);

   logic [31:0] w_imm32;
   logic        w_legal;
   logic        w_unused_opcode;

   assign w_unused_opcode = ^i_instruction[6:0];

   // Zimm is built with bit 31 clear so the common sign-extension below zero-extends it.
   always_comb begin
      w_imm32 = '0;
      case (imm_src_e'(i_imm_src))
         IMM_I:   w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
         IMM_S:   w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
         IMM_B:   w_imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                             i_instruction[30:25], i_instruction[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_instruction[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                             i_instruction[20], i_instruction[30:21], 1'b0};
         IMM_Z:   w_imm32 = {27'b0, i_instruction[19:15]};
         default: w_imm32 = '0;
      endcase
   end

   assign w_legal   = imm_src_legal(i_imm_src);
   assign o_illegal = !w_legal;
   assign o_imm_ext = w_legal ? XLEN'($signed(w_imm32)) : '0;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender behind a valid/ready handshake with an
// output register plus one skid entry; zimm support follows IMM_EXT_ZICSR_UIMM_EN.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic             illegal_seen
);

   logic [XLEN-1:0]  w_core_imm;
   logic             w_core_ill;
   logic             w_accept;
   logic             w_out_free;

   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_imm;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_out_ill;
   logic             r_skid_valid;
   logic [XLEN-1:0]  r_skid_imm;
   logic [TAG_W-1:0] r_skid_tag;
   logic             r_skid_ill;
   logic             r_illegal_seen;

   imm_ext_core #(.XLEN(XLEN)) u_core (
      .i_instruction (instruction),
      .i_imm_src     (imm_src),
      .o_imm_ext     (w_core_imm),
      .o_illegal     (w_core_ill)
   );

   // in_ready comes straight from the skid flop, keeping out_ready off the input path.
   assign w_accept   = in_valid && !r_skid_valid && !flush;
   assign w_out_free = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid    <= 1'b0;
         r_out_imm      <= '0;
         r_out_tag      <= '0;
         r_out_ill      <= 1'b0;
         r_skid_valid   <= 1'b0;
         r_skid_imm     <= '0;
         r_skid_tag     <= '0;
         r_skid_ill     <= 1'b0;
         r_illegal_seen <= 1'b0;
      end else begin
         if (w_accept && w_core_ill) r_illegal_seen <= 1'b1;
         if (flush) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_tag    <= '0;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
         end else if (w_out_free) begin
            if (r_skid_valid) begin
               r_out_valid  <= 1'b1;
               r_out_imm    <= r_skid_imm;
               r_out_tag    <= r_skid_tag;
               r_out_ill    <= r_skid_ill;
               r_skid_valid <= 1'b0;
            end else begin
               r_out_valid <= w_accept;
               if (w_accept) begin
                  r_out_imm <= w_core_imm;
                  r_out_tag <= in_tag;
                  r_out_ill <= w_core_ill;
               end
            end
         end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_core_imm;
            r_skid_tag   <= in_tag;
            r_skid_ill   <= w_core_ill;
         end
      end
   end

   assign in_ready     = !r_skid_valid;
   assign out_valid    = r_out_valid;
   assign imm_ext      = r_out_imm;
   assign out_tag      = r_out_tag;
   assign out_illegal  = r_out_ill;
   assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// directed vectors with hand-computed immediates, backpressure, flush and reset cases.
module tb_imm_ext_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [3:0]  tag;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [2:0]  imm_src;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imm_ext;
   logic [3:0]  out_tag;
   logic        out_illegal;
   logic        illegal_seen;

   logic        in_ready64, out_valid64, out_illegal64, illegal_seen64;
   logic [63:0] imm_ext64;
   logic [3:0]  out_tag64;

   logic [63:0] cur_exp;
   logic        cur_ill;

   int checks = 0;
   int errors = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .imm_ext(imm_ext), .out_tag(out_tag),
      .out_illegal(out_illegal), .illegal_seen(illegal_seen)
   );

   imm_ext_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .instruction(instruction), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm_ext64), .out_tag(out_tag64),
      .out_illegal(out_illegal64), .illegal_seen(illegal_seen64)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [3:0] tag,
                       input logic [63:0] e, input logic il);
      int n;
      instruction = ins;
      imm_src     = src;
      in_tag      = tag;
      cur_exp     = e;
      cur_ill     = il;
      in_valid    = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout tag=%0d: in_ready=%0b want 1", tag, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // expected-response pusher
   always @(negedge clk) begin
      if (!rst_n || flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{imm: cur_exp, tag: in_tag, ill: cur_ill});
   end

   // output monitor: beat compare and stall stability
   logic        held = 1'b0;
   logic [31:0] held_imm;
   logic [63:0] held_imm64;
   logic [3:0]  held_tag;
   logic        held_ill;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held && out_valid) begin
            checks++;
            if (imm_ext !== held_imm || imm_ext64 !== held_imm64 ||
                out_tag !== held_tag || out_illegal !== held_ill) begin
               errors++;
               $display("FAIL stall_stable: got imm=%h imm64=%h tag=%0d ill=%0b want imm=%h imm64=%h tag=%0d ill=%0b",
                        imm_ext, imm_ext64, out_tag, out_illegal, held_imm, held_imm64, held_tag, held_ill);
            end
         end
         held       = out_valid && !out_ready && !flush;
         held_imm   = imm_ext;
         held_imm64 = imm_ext64;
         held_tag   = out_tag;
         held_ill   = out_illegal;
         if (out_valid && out_ready && !flush) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got tag=%0d imm=%h want no beat", out_tag, imm_ext);
            end else begin
               e = q.pop_front();
               if (imm_ext !== e.imm[31:0] || imm_ext64 !== e.imm || out_tag !== e.tag ||
                   out_illegal !== e.ill || out_illegal64 !== e.ill) begin
                  errors++;
                  $display("FAIL beat tag=%0d: got imm=%h imm64=%h tag=%0d ill=%0b want imm=%h imm64=%h tag=%0d ill=%0b",
                           e.tag, imm_ext, imm_ext64, out_tag, out_illegal, e.imm[31:0], e.imm, e.tag, e.ill);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction = '0; imm_src = '0; in_tag = '0; cur_exp = '0; cur_ill = 1'b0;
      #12;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_imm_ext", 64'(imm_ext), 64'd0);
      chk("reset_imm_ext64", imm_ext64, 64'd0);
      chk("reset_tag_ill_seen", {out_tag, out_illegal, illegal_seen}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_in_ready", 64'(in_ready), 64'd1);
      chk("post_reset_out_valid", 64'(out_valid), 64'd0);

      out_ready = 1'b1;
      send(32'hFFF00013, 3'b000, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send(32'h0064A423, 3'b001, 4'd2, 64'h0000_0000_0000_0008, 1'b0);
      send(32'hFE420AE3, 3'b010, 4'd3, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
      send(32'h12345037, 3'b011, 4'd4, 64'h0000_0000_1234_5000, 1'b0);
      send(32'h80000037, 3'b011, 4'd5, 64'hFFFF_FFFF_8000_0000, 1'b0);
      send(32'h008000EF, 3'b100, 4'd6, 64'h0000_0000_0000_0008, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("illegal_seen_clear", 64'(illegal_seen), 64'd0);

      send(32'hFFFFFFFF, 3'b110, 4'd7, 64'd0, 1'b1);
      chk("illegal_seen_set", 64'(illegal_seen), 64'd1);
      send(32'hFFF00013, 3'b111, 4'd8, 64'd0, 1'b1);
`ifdef IMM_EXT_ZICSR_UIMM_EN
      send(32'h000F5073, 3'b101, 4'd9, 64'h0000_0000_0000_001E, 1'b0);
`else
      send(32'h000F5073, 3'b101, 4'd9, 64'd0, 1'b1);
`endif
      repeat (2) @(posedge clk);
      #1;

      // backpressure: two beats fill output and skid, then release
      out_ready = 1'b0;
      send(32'h00100093, 3'b000, 4'd0, 64'd1, 1'b0);
      send(32'h00200093, 3'b000, 4'd1, 64'd2, 1'b0);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_tag_head", 64'(out_tag), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("bp_still_blocked", {in_ready, out_valid}, 64'b01);
      out_ready = 1'b1;
      send(32'hFFE00093, 3'b000, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      send(32'h7FF00093, 3'b000, 4'd3, 64'h0000_0000_0000_07FF, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // flush with two beats held
      out_ready = 1'b0;
      send(32'h00300093, 3'b000, 4'd10, 64'd3, 1'b0);
      send(32'h00400093, 3'b000, 4'd11, 64'd4, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_keeps_seen", 64'(illegal_seen), 64'd1);

      // beat presented together with flush is dropped
      out_ready   = 1'b1;
      instruction = 32'h00500093; imm_src = 3'b000; in_tag = 4'd12; cur_exp = 64'd5; cur_ill = 1'b0;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_drop_beat", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("flush_drop_beat_later", 64'(out_valid), 64'd0);

      // asynchronous reset mid-stall
      out_ready = 1'b0;
      send(32'h00600093, 3'b000, 4'd13, 64'd6, 1'b0);
      send(32'hFFF00093, 3'b000, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_imm", 64'(imm_ext), 64'd0);
      chk("rst_mid_imm64", imm_ext64, 64'd0);
      chk("rst_mid_tag_ill_seen", {out_tag, out_illegal, illegal_seen}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_release_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_stale_beat", 64'(out_valid), 64'd0);

      n = 0;
      while (q.size() != 0 && n < 50) begin
         n++;
         @(posedge clk);
      end
      #1;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
